// File: rtl/replicate_fork.sv
// Buffered broadcast stage: each pushed item is offered on every output channel and
// retires from the FIFO only once all channels have taken it.
module replicate_fork #(
  parameter int unsigned ITEM_SIZE          = 8,
  parameter int unsigned REPLICATION_FACTOR = 3,
  parameter int unsigned BUFFER_DEPTH       = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [ITEM_SIZE-1:0]                     in_data,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic [ITEM_SIZE*REPLICATION_FACTOR-1:0]  out_data,
  output logic [REPLICATION_FACTOR-1:0]            out_valid,
  input  logic [REPLICATION_FACTOR-1:0]            out_ready,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]        occupancy
);

  localparam int unsigned PtrW = $clog2(BUFFER_DEPTH);
  localparam int unsigned OccW = $clog2(BUFFER_DEPTH + 1);

  logic [ITEM_SIZE-1:0]          mem_q [BUFFER_DEPTH];
  logic [ITEM_SIZE-1:0]          mem_d [BUFFER_DEPTH];
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]               occ_q, occ_d;
  logic [REPLICATION_FACTOR-1:0] taken_q, taken_d;

  logic                          not_empty;
  logic                          push;
  logic                          retire;
  logic [REPLICATION_FACTOR-1:0] fire;
  logic [ITEM_SIZE-1:0]          head;

  assign not_empty = (occ_q != '0);
  // Ready is gated by reset and never looks at same-cycle retires.
  assign in_ready  = rst_n & (occ_q != OccW'(BUFFER_DEPTH));
  assign push      = in_valid & in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int unsigned i = 0; i < REPLICATION_FACTOR; i++) begin
      out_data[i*ITEM_SIZE +: ITEM_SIZE] = head;
      out_valid[i]                       = not_empty & ~taken_q[i];
    end
  end

  assign fire   = out_valid & out_ready;
  assign retire = not_empty & (&(taken_q | fire));

  always_comb begin
    for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    taken_d  = taken_q | fire;
    occ_d    = occ_q + OccW'(push) - OccW'(retire);

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    // Retiring clears every taken flag, including the ones firing this cycle.
    if (retire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      taken_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      taken_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      taken_q  <= taken_d;
    end
  end

endmodule

// File: tb/tb_replicate_fork.sv
// Self-checking bench for replicate_fork: per-channel scoreboards plus directed
// checks of occupancy, ready and per-channel valid.
module tb_replicate_fork;

  localparam int unsigned Item  = 8;
  localparam int unsigned Rf    = 3;
  localparam int unsigned Depth = 4;
  localparam int unsigned OccW  = $clog2(Depth + 1);

  logic                 clk;
  logic                 rst_n;
  logic [Item-1:0]      in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [Item*Rf-1:0]   out_data;
  logic [Rf-1:0]        out_valid;
  logic [Rf-1:0]        out_ready;
  logic [OccW-1:0]      occupancy;

  int checks;
  int failures;

  logic [Item-1:0] sb_q [Rf][$];

  replicate_fork #(
    .ITEM_SIZE         (Item),
    .REPLICATION_FACTOR(Rf),
    .BUFFER_DEPTH      (Depth)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample the handshakes on the falling edge; they take effect at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < Rf; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (sb_q[i].size() == 0) begin
            check($sformatf("spurious_ch%0d", i), {31'd0, out_valid[i]}, 32'd0);
          end else begin
            check($sformatf("data_ch%0d", i), {24'd0, out_data[i*Item +: Item]},
                  {24'd0, sb_q[i].pop_front()});
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < Rf; i++) sb_q[i].push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input logic [Item-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("push_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 200 && occupancy != 0; n++) tick();
    check("drain_occ", {29'd0, occupancy}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '0;

    // Reset then idle
    #12;
    check("rst_out_valid", {29'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_occ", {29'd0, occupancy}, 32'd0);
    check("rst_out_data", {8'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Lockstep flow
    out_ready = 3'b111;
    push_item(8'h11);
    check("lock_valid1", {29'd0, out_valid}, 32'd7);
    check("lock_occ1", {29'd0, occupancy}, 32'd1);
    push_item(8'h22);
    check("lock_occ2", {29'd0, occupancy}, 32'd1);
    push_item(8'h33);
    check("lock_occ3", {29'd0, occupancy}, 32'd1);
    check("lock_head", {8'd0, out_data}, 32'h333333);
    wait_empty();

    // Staggered consumers
    out_ready = 3'b000;
    push_item(8'hA5);
    check("stag_v0", {29'd0, out_valid}, 32'd7);
    out_ready = 3'b001;
    tick();
    check("stag_v1", {29'd0, out_valid}, 32'd6);
    out_ready = 3'b000;
    tick();
    out_ready = 3'b100;
    tick();
    check("stag_v2", {29'd0, out_valid}, 32'd2);
    check("stag_occ_before", {29'd0, occupancy}, 32'd1);
    out_ready = 3'b000;
    tick();
    out_ready = 3'b010;
    tick();
    check("stag_v3", {29'd0, out_valid}, 32'd0);
    check("stag_occ_after", {29'd0, occupancy}, 32'd0);

    // Full
    out_ready = 3'b000;
    for (int k = 0; k < 4; k++) push_item(8'h40 + 8'(k));
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_occ", {29'd0, occupancy}, 32'd4);
    in_valid = 1'b1;
    in_data  = 8'h44;
    tick();
    tick();
    check("full_held_occ", {29'd0, occupancy}, 32'd4);
    check("full_held_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 3'b111;
    push_item(8'h44);
    wait_empty();

    // Simultaneous push and retire, then wrap
    out_ready = 3'b000;
    push_item(8'h51);
    push_item(8'h52);
    check("sim_occ_pre", {29'd0, occupancy}, 32'd2);
    in_valid  = 1'b1;
    in_data   = 8'h53;
    out_ready = 3'b111;
    tick();
    in_valid  = 1'b0;
    out_ready = 3'b000;
    check("sim_occ_same", {29'd0, occupancy}, 32'd2);
    out_ready = 3'b111;
    for (int k = 0; k < 10; k++) push_item(8'h60 + 8'(k));
    wait_empty();
    for (int i = 0; i < Rf; i++) check($sformatf("sb_empty_ch%0d", i), sb_q[i].size(), 32'd0);

    // Reset mid-operation
    out_ready = 3'b000;
    push_item(8'h71);
    push_item(8'h72);
    push_item(8'h73);
    out_ready = 3'b010;
    tick();
    out_ready = 3'b000;
    check("mid_occ", {29'd0, occupancy}, 32'd3);
    check("mid_valid", {29'd0, out_valid}, 32'd5);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < Rf; i++) sb_q[i].delete();
    #1;
    check("mid_rst_valid", {29'd0, out_valid}, 32'd0);
    check("mid_rst_occ", {29'd0, occupancy}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_data", {8'd0, out_data}, 32'd0);
    tick();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 3'b111;
    tick();
    tick();
    check("post_mid_valid", {29'd0, out_valid}, 32'd0);
    check("post_mid_occ", {29'd0, occupancy}, 32'd0);
    push_item(8'h77);
    check("post_mid_head", {8'd0, out_data}, 32'h777777);
    wait_empty();
    for (int i = 0; i < Rf; i++) check($sformatf("sb_final_ch%0d", i), sb_q[i].size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/replicate_fork.md
Name: replicate_fork

Overview:
- Buffered broadcast stage: each input item is copied to REPLICATION_FACTOR output channels.
- Each channel has its own valid/ready, so consumers may accept at different cycles.
- A FIFO of BUFFER_DEPTH entries decouples the producer from the slowest consumer.
- An entry retires only after every channel has taken it.
- Sits between a single producer and several independent downstream pipelines.

Parameters:
- ITEM_SIZE, 8, width of one item in bits.
- REPLICATION_FACTOR, 3, number of output channels (>= 1).
- BUFFER_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  ITEM_SIZE  item from producer.
- in_valid  input  1  producer has an item.
- in_ready  output  1  FIFO can accept an item this cycle.
- out_data  output  ITEM_SIZE*REPLICATION_FACTOR  head item replicated; channel i occupies bits [ITEM_SIZE*(i+1)-1 : ITEM_SIZE*i].
- out_valid  output  REPLICATION_FACTOR  per-channel valid.
- out_ready  input  REPLICATION_FACTOR  per-channel ready.
- occupancy  output  $clog2(BUFFER_DEPTH+1)  entries currently held, including a partially consumed head.

Behaviour:
- Reset (rst_n low, asynchronous):
  - write and read pointers 0, occupancy 0, per-channel taken[] flags 0.
  - All storage entries 0, so out_data = 0 and out_valid = 0.
  - in_ready is forced 0 while rst_n is low; it is 1 on the first cycle after release.
- Push: push = in_valid & in_ready; in_ready = (occupancy != BUFFER_DEPTH) when out of reset.
  - On push, in_data is written at the write pointer and the write pointer increments.
  - in_ready does not depend on same-cycle pops. When full, in_ready stays 0 even if the head retires that cycle; there is no combinational ready path from out_ready to in_ready.
- Latency: an item pushed at edge N is visible on out_data/out_valid in the cycle after edge N, when the FIFO was empty. There is no bypass.
- Head presentation:
  - out_data replicates the entry at the read pointer on every channel.
  - out_valid[i] = (occupancy != 0) & ~taken[i].
- Channel handshake: channel i fires when out_valid[i] & out_ready[i]; at the edge, taken[i] is set to 1.
- Retire: retire = (occupancy != 0) & AND over i of (taken[i] | fire[i]).
  - On retire, the read pointer increments and all taken[] clear to 0. No taken bit is set for the retired entry.
  - The next entry's out_valid rises in the following cycle, provided occupancy stays nonzero.
- Occupancy: next = occupancy + push - retire.
  - Simultaneous push and retire leave occupancy unchanged; pointers wrap modulo BUFFER_DEPTH.
- Ordering: items leave every channel in push order. A channel that has taken the head never sees it again and waits (out_valid[i] = 0) until the entry retires.
- Stability: while out_valid[i] = 1 and the channel has not fired, out_data slice i holds constant.
- out_ready is ignored when the FIFO is empty; taken bits never set while occupancy = 0.
- REPLICATION_FACTOR = 1 degenerates to a plain FIFO of BUFFER_DEPTH.
- Reset mid-operation: all stored and partially consumed items are discarded. Outputs return to the reset values above immediately, without waiting for a clock.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low, then release.
  - Required: during reset out_valid = 000, in_ready = 0, occupancy = 0; after release in_ready = 1.
- Lockstep flow:
  - Stimulus: out_ready = 111, push 0x11, 0x22, 0x33 on consecutive cycles.
  - Required: each item appears on all three slices one cycle after its push; occupancy never exceeds 1; order is 0x11, 0x22, 0x33.
- Staggered consumers:
  - Stimulus: push 0xA5; channel 0 ready at cycle 1, channel 2 at cycle 3, channel 1 at cycle 5.
  - Required: out_valid goes 111 -> 110 -> 010 -> 000; entry retires at cycle 5; occupancy 1 -> 0.
- Full:
  - Stimulus: out_ready = 000, push 5 items with BUFFER_DEPTH = 4.
  - Required: first 4 are accepted; in_ready = 0 after the 4th push; occupancy = 4; the 5th is held by the producer.
- Simultaneous push and retire, then wrap:
  - Stimulus: at occupancy 2, retire the head in the same cycle as a push; then run 10 items through.
  - Required: occupancy stays 2 on that cycle; all 10 items emerge in order across the pointer wrap.
- Reset mid-operation:
  - Stimulus: occupancy 3 with channel 1 already taken; assert rst_n low asynchronously between edges.
  - Required: out_valid = 000 and occupancy = 0 immediately; after release, none of the old items reappear.
